// File: rtl/ray_gen.sv
`timescale 1ns/1ps
// ray_gen: primary-ray generator for one square frame.
// A start pulse latches origin and direction basis. The block then emits one
// ray per pixel in row-major order, x fastest. Each direction is built by
// incremental addition: +du per column, and +dv on a row accumulator per row.
// Ports:
//   clock, reset      single clock, asynchronous active-high reset
//   start             request one frame (sampled in IDLE only)
//   origin, dir_base  ray origin and the direction of pixel (0,0); 3 x D_BITS
//   du, dv            per-column / per-row direction steps; 3 x D_BITS
//   in_full           downstream FIFO full
//   in_wr_en          ray write strobe, combinational: EMIT and not full
//   ray_out           [0..2] origin x,y,z, [3..5] direction x,y,z
//   pixel_x, pixel_y  pixel coordinates of the ray on ray_out
//   busy, done        frame in progress / one-cycle completion pulse
// Vector words are two's-complement signed. They are carried as plain bit
// vectors because wrapping addition is sign-agnostic.
module ray_gen #(
  parameter int unsigned D_BITS   = 32,
  parameter int unsigned Q_BITS   = 16,
  parameter int unsigned RES_LOG2 = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0][D_BITS-1:0]       origin,
  input  logic [2:0][D_BITS-1:0]       dir_base,
  input  logic [2:0][D_BITS-1:0]       du,
  input  logic [2:0][D_BITS-1:0]       dv,
  input  logic                         in_full,
  output logic                         in_wr_en,
  output logic [5:0][D_BITS-1:0]       ray_out,
  output logic [RES_LOG2-1:0]          pixel_x,
  output logic [RES_LOG2-1:0]          pixel_y,
  output logic                         busy,
  output logic                         done
);

  // The fraction width only describes the number format; no logic depends on it.
  if (Q_BITS >= D_BITS) begin : g_bad_q
    $error("ray_gen: Q_BITS must be smaller than D_BITS");
  end

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

  state_t                  state;
  logic [2:0][D_BITS-1:0]  org_q;
  logic [2:0][D_BITS-1:0]  base_q;
  logic [2:0][D_BITS-1:0]  du_q;
  logic [2:0][D_BITS-1:0]  dv_q;
  logic [2:0][D_BITS-1:0]  row_acc;
  logic [2:0][D_BITS-1:0]  row_next;
  logic [2:0][D_BITS-1:0]  dir_step;
  logic                    last_col;
  logic                    last_row;

  // Write strobe follows backpressure within the same cycle.
  assign in_wr_en = (state == EMIT) && !in_full;
  assign last_col = &pixel_x;
  assign last_row = &pixel_y;

  // Next-column and next-row direction candidates.
  always_comb begin
    row_next = '0;
    dir_step = '0;
    for (int c = 0; c < 3; c++) begin
      row_next[c] = row_acc[c] + dv_q[c];
      dir_step[c] = ray_out[3+c] + du_q[c];
    end
  end

  // Frame sequencer, configuration latch and direction accumulators.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ray_out <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      org_q   <= '0;
      base_q  <= '0;
      du_q    <= '0;
      dv_q    <= '0;
      row_acc <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            org_q  <= origin;
            base_q <= dir_base;
            du_q   <= du;
            dv_q   <= dv;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          ray_out <= {base_q, org_q};
          row_acc <= base_q;
          pixel_x <= '0;
          pixel_y <= '0;
          state   <= EMIT;
        end
        EMIT: begin
          // Advance only on a transfer; a stall holds ray_out and the pixel.
          if (!in_full) begin
            if (last_col) begin
              pixel_x       <= '0;
              pixel_y       <= pixel_y + RES_LOG2'(1);
              row_acc       <= row_next;
              ray_out[5:3]  <= row_next;
              if (last_row) begin
                done  <= 1'b1;
                state <= FIN;
              end
            end else begin
              pixel_x      <= pixel_x + RES_LOG2'(1);
              ray_out[5:3] <= dir_step;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
`timescale 1ns/1ps
// Bench for ray_gen. When a frame starts, every expected ray is queued. A
// negedge monitor pops one entry for each write strobe and compares it.
module tb_ray_gen;

  localparam int unsigned D = 32;
  localparam int unsigned R = 5;
  localparam int unsigned N = 1024;

  typedef struct packed {
    logic [5:0][D-1:0] ray;
    logic [9:0]        pix;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_full = 1'b0;
  logic [2:0][D-1:0] origin, dir_base, du, dv;
  logic              in_wr_en;
  logic [5:0][D-1:0] ray_out;
  logic [R-1:0]      pixel_x, pixel_y;
  logic              busy, done;

  int   vectors = 0;
  int   errors  = 0;
  int   writes  = 0;
  int   dones   = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [2:0][D-1:0] rec_dir [N];

  ray_gen #(.D_BITS(D), .Q_BITS(16), .RES_LOG2(R)) dut (
    .clock(clock), .reset(reset), .start(start),
    .origin(origin), .dir_base(dir_base), .du(du), .dv(dv),
    .in_full(in_full), .in_wr_en(in_wr_en), .ray_out(ray_out),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Scoreboard consumer: each strobe transfers exactly the head of the queue.
  always @(negedge clock) begin
    if (done) dones++;
    if (!reset && in_wr_en) begin
      writes++;
      if (q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        mon_e = q.pop_front();
        check("ray", ray_out, mon_e.ray);
        check("pixel", {pixel_y, pixel_x}, mon_e.pix);
        rec_dir[mon_e.pix] = ray_out[5:3];
      end
    end
  end

  // Reference: direct evaluation dir_base + x*du + y*dv, wrapping at D bits.
  task automatic push_frame();
    exp_t e;
    int unsigned x, y;
    for (int k = 0; k < int'(N); k++) begin
      x = k % 32;
      y = k / 32;
      e.pix = 10'(k);
      for (int c = 0; c < 3; c++) begin
        e.ray[c]   = origin[c];
        e.ray[3+c] = dir_base[c] + 32'(x) * du[c] + 32'(y) * dv[c];
      end
      q.push_back(e);
    end
  endtask

  task automatic start_frame();
    @(posedge clock);
    #1;
    push_frame();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // lat is the number of edges from the start edge to the edge that captures done.
  task automatic wait_done(output int lat);
    int cyc;
    cyc = 0;
    lat = -1;
    while (cyc < 3000) begin
      @(negedge clock);
      if (done) begin
        lat = cyc + 1;
        break;
      end
      @(posedge clock);
      cyc++;
    end
    if (lat < 0) fail_now("done_timeout");
  endtask

  // Return just after the edge that makes ray k the pending ray.
  task automatic wait_pix(input int k);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #1;
      if (busy && int'({pixel_y, pixel_x}) == k) return;
    end
    fail_now("wait_pix");
  endtask

  task automatic set_basic();
    origin   = {32'hFFFB0000, 32'h0, 32'h0};
    dir_base = {32'h00010000, 32'hFFFF0000, 32'hFFFF0000};
    du       = {32'h0, 32'h0, 32'h00001000};
    dv       = {32'h0, 32'h00001000, 32'h0};
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ray"}, ray_out, '0);
    check({tag, "_pix"}, {pixel_y, pixel_x}, '0);
    check({tag, "_ctl"}, {busy, done, in_wr_en}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, w0, d0;
    logic [5:0][D-1:0] saved;
    set_basic();

    #2 reset = 1'b1;
    #2 check_reset_outs("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic frame.
    w0 = writes; d0 = dones;
    start_frame();
    wait_done(lat);
    check("basic_latency", 32'(lat), 32'd1026);
    check("basic_writes", 32'(writes - w0), 32'd1024);
    check("basic_ray33", rec_dir[33], {32'h00010000, 32'hFFFF1000, 32'hFFFF1000});
    repeat (2) @(negedge clock);
    check("basic_done_once", 32'(dones - d0), 32'd1);
    check("basic_idle", {busy, in_wr_en}, 2'b00);
    check("basic_queue_empty", 32'(q.size()), 32'd0);

    // Backpressure on ray 40 for 3 cycles and on the final ray for 4 cycles.
    w0 = writes;
    start_frame();
    fork
      wait_done(lat);
      begin
        wait_pix(40);
        in_full = 1'b1;
        saved = ray_out;
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("bp40_wr_en", in_wr_en, 1'b0);
          check("bp40_hold", ray_out, saved);
          @(posedge clock);
          #1;
        end
        in_full = 1'b0;
        wait_pix(1023);
        in_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          check("bplast_wr_done", {in_wr_en, done}, 2'b00);
          @(posedge clock);
          #1;
        end
        in_full = 1'b0;
      end
    join
    check("bp_latency", 32'(lat), 32'd1033);
    check("bp_writes", 32'(writes - w0), 32'd1024);
    check("bp_ray40", rec_dir[40], {32'h00010000, 32'hFFFF1000, 32'hFFFF8000});

    // Start and new configuration mid-frame have no effect.
    w0 = writes;
    start_frame();
    fork
      wait_done(lat);
      begin
        wait_pix(300);
        start  = 1'b1;
        du     = {32'h5, 32'h5, 32'h5};
        origin = {32'h1, 32'h2, 32'h3};
        @(posedge clock);
        #1 start = 1'b0;
      end
    join
    check("cfg_latency", 32'(lat), 32'd1026);
    check("cfg_writes", 32'(writes - w0), 32'd1024);
    set_basic();

    // Direction wraps from the positive maximum.
    dir_base[0] = 32'h7FFFF000;
    start_frame();
    wait_done(lat);
    check("wrap_ray1_x", rec_dir[1][0], 32'h80000000);
    set_basic();

    // Reset asserted asynchronously at ray 500.
    start_frame();
    wait_pix(500);
    #3 reset = 1'b1;
    #1 check_reset_outs("midreset");
    q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    w0 = writes;
    repeat (20) @(posedge clock);
    check("post_reset_no_writes", 32'(writes - w0), 32'd0);
    check("post_reset_idle", busy, 1'b0);
    w0 = writes;
    start_frame();
    wait_done(lat);
    check("after_reset_latency", 32'(lat), 32'd1026);
    check("after_reset_writes", 32'(writes - w0), 32'd1024);

    // Two back-to-back frames, the second started the cycle after done.
    w0 = writes;
    start_frame();
    wait_done(lat);
    start_frame();
    wait_done(lat2);
    check("b2b_latency1", 32'(lat), 32'd1026);
    check("b2b_latency2", 32'(lat2), 32'd1026);
    check("b2b_writes", 32'(writes - w0), 32'd2048);
    repeat (2) @(negedge clock);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ray_gen.md
RAY_GEN -- requirements
Module: ray_gen

Interface
REQ-001 Parameters SHALL be:
- D_BITS, default 32, signed fixed-point word width.
- Q_BITS, default 16, fraction bits; carried through unchanged, no arithmetic dependence.
- RES_LOG2, default 5, log2 of the frame edge, giving a 32x32 = 1024-ray frame.
REQ-002 Ports SHALL be, in order:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request one frame.
- origin  in  3 x D_BITS signed  ray origin x,y,z.
- dir_base  in  3 x D_BITS signed  direction of pixel (0,0).
- du  in  3 x D_BITS signed  per-column direction step.
- dv  in  3 x D_BITS signed  per-row direction step.
- in_full  in  1  downstream ray FIFO full.
- in_wr_en  out  1  ray write strobe.
- ray_out  out  6 x D_BITS signed  [0..2] origin, [3..5] direction.
- pixel_x  out  RES_LOG2  column of the current ray.
- pixel_y  out  RES_LOG2  row of the current ray.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
REQ-003 One clock domain; reset is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, EMIT, FIN.
REQ-005 IDLE, start=1 -> LOAD; origin, dir_base, du and dv are latched internally at that edge.
REQ-006 LOAD -> EMIT after exactly one cycle; ray_out = {origin, dir_base}, pixel_x = pixel_y = 0.
REQ-007 In EMIT, in_wr_en = ~in_full (combinational); in_wr_en is 0 in every other state.
REQ-008 A ray transfers on each posedge where in_wr_en=1.
REQ-009 When in_full=1, no transfer occurs, and ray_out, pixel_x and pixel_y hold.
REQ-010 Each transfer SHALL advance the frame in row-major order, x fastest.
- Non-last column: direction += du; pixel_x += 1.
- Last column: pixel_x = 0; pixel_y += 1; row accumulator += dv; direction = new row accumulator.
REQ-011 Direction SHALL be computed by incremental addition only, no multipliers.
REQ-012 Every addition is D_BITS two's-complement; overflow wraps silently.
REQ-013 Ray k = y*2^RES_LOG2 + x SHALL carry direction dir_base + x*du + y*dv (mod 2^D_BITS) and origin unchanged.
REQ-014 Transfer of ray (2^RES_LOG2-1, 2^RES_LOG2-1) -> FIN.
REQ-015 FIN lasts one cycle with done=1, then -> IDLE.
REQ-016 busy=1 in LOAD, EMIT and FIN; busy=0 in IDLE.
REQ-017 start is ignored outside IDLE; changes to configuration inputs after the latch have no effect until the next frame.
REQ-018 Throughput SHALL be one ray per cycle while in_full=0.
REQ-019 Minimum frame duration SHALL be 2 + 2^(2*RES_LOG2) cycles: start edge to done, with in_full=0 throughout.
REQ-020 in_full asserted on the cycle of the final ray SHALL delay FIN until that ray transfers; no ray is dropped or duplicated.

Reset
REQ-021 Reset SHALL force immediately, regardless of clock:
- state = IDLE
- in_wr_en = 0, done = 0, busy = 0
- ray_out = 0, pixel_x = 0, pixel_y = 0
- all accumulators = 0
REQ-022 Reset mid-frame SHALL abandon the frame; after reset release, no further writes occur until a new start.

Verification
REQ-023 Basic frame:
- Stimulus: origin=(0,0,0xFFFB0000), dir_base=(0xFFFF0000,0xFFFF0000,0x00010000), du=(0x00001000,0,0), dv=(0,0x00001000,0), in_full=0, start pulse.
- Response: exactly 1024 writes on consecutive cycles; ray 33 direction = (0xFFFF1000,0xFFFF1000,0x00010000); done pulses once, 1026 cycles after start.
REQ-024 Backpressure:
- Stimulus: in_full high for 3 cycles during ray 40, and again while the final ray is pending.
- Response: in_wr_en=0 during those cycles; ray 40 transferred exactly once with unchanged ray_out; total writes = 1024.
REQ-025 Wrap:
- Stimulus: dir_base.x=0x7FFFF000, du.x=0x00001000.
- Response: ray 1 direction.x = 0x80000000.
REQ-026 Start/config during frame:
- Stimulus: start and new du asserted mid-frame.
- Response: ignored; sequence identical to REQ-023.
REQ-027 Reset mid-frame:
- Stimulus: reset asserted asynchronously at ray 500.
- Response: outputs zero before the next posedge; no writes afterwards; a subsequent start yields a full 1024-ray frame from pixel (0,0).
REQ-028 Two back-to-back frames:
- Stimulus: second start issued the cycle after done.
- Response: second frame is bit-identical to the first.
